// File: rtl/rect_fill_renderer.sv
// Filled-rectangle renderer: turns (x, y, w, h, colour) commands into one
// frame-buffer pixel write per clock, row-major, clipped to the frame.
module rect_fill_renderer #(
    parameter int unsigned W      = 320,
    parameter int unsigned H      = 240,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned XW     = 9,
    parameter int unsigned YW     = 8
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [XW-1:0]     cmd_x,
    input  logic [YW-1:0]     cmd_y,
    input  logic [XW-1:0]     cmd_w,
    input  logic [YW-1:0]     cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    output logic              busy,
    output logic              done,
    output logic              fb_en,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_din
);

    localparam int unsigned XEW = XW + 1;
    localparam int unsigned YEW = YW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRAW,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [XW-1:0]     x_q, w_q, cx;
    logic [YW-1:0]     y_q, h_q, cy;
    logic [DATA_W-1:0] color_q;
    logic [XEW-1:0]    x_end;
    logic [YEW-1:0]    y_end;
    logic [ADDR_W-1:0] row_base;

    logic              accept;
    logic              empty;
    logic              col_last;
    logic              row_last;
    logic [XEW-1:0]    x_sum, x_end_n;
    logic [YEW-1:0]    y_sum, y_end_n;
    logic [ADDR_W-1:0] top_base;

    // Next-state logic plus clipping / end-of-row decode
    always_comb begin
        state_n  = state;
        accept   = cmd_valid && cmd_ready;
        x_sum    = XEW'(x_q) + XEW'(w_q);
        y_sum    = YEW'(y_q) + YEW'(h_q);
        x_end_n  = (x_sum > XEW'(W)) ? XEW'(W) : x_sum;
        y_end_n  = (y_sum > YEW'(H)) ? YEW'(H) : y_sum;
        empty    = (w_q == '0) || (h_q == '0) ||
                   (XEW'(x_q) >= XEW'(W)) || (YEW'(y_q) >= YEW'(H));
        top_base = ADDR_W'(y_q) * ADDR_W'(W);
        col_last = (XEW'(cx) + XEW'(1)) == x_end;
        row_last = (YEW'(cy) + YEW'(1)) == y_end;

        case (state)
            S_IDLE:  if (accept) state_n = S_SETUP;
            S_SETUP: state_n = empty ? S_DONE : S_DRAW;
            S_DRAW:  if (col_last && row_last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_sys) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Command latch, pixel walker and registered outputs (decoded from next state)
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            fb_en     <= 1'b0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_din    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            cx        <= '0;
            cy        <= '0;
            x_end     <= '0;
            y_end     <= '0;
            row_base  <= '0;
        end else begin
            cmd_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
            fb_en     <= (state_n == S_DRAW);
            fb_we     <= (state_n == S_DRAW);

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        color_q <= cmd_color;
                    end
                end
                S_SETUP: begin
                    x_end    <= x_end_n;
                    y_end    <= y_end_n;
                    cx       <= x_q;
                    cy       <= y_q;
                    row_base <= top_base;
                    if (!empty) begin
                        fb_addr <= top_base + ADDR_W'(x_q);
                        fb_din  <= color_q;
                    end
                end
                S_DRAW: begin
                    if (!(col_last && row_last)) begin
                        if (col_last) begin
                            cx       <= x_q;
                            cy       <= cy + YW'(1);
                            row_base <= row_base + ADDR_W'(W);
                            fb_addr  <= row_base + ADDR_W'(W) + ADDR_W'(x_q);
                        end else begin
                            cx      <= cx + XW'(1);
                            fb_addr <= fb_addr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_renderer.sv
// Bench for rect_fill_renderer: directed corner cases plus random rectangles,
// checked by a scoreboard fed from a pixel-list reference model.
module tb_rect_fill_renderer;

    localparam int W = 320;
    localparam int H = 240;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x = '0;
    logic [7:0]  cmd_y = '0;
    logic [8:0]  cmd_w = '0;
    logic [7:0]  cmd_h = '0;
    logic [15:0] cmd_color = '0;
    logic        busy, done, fb_en, fb_we;
    logic [16:0] fb_addr;
    logic [15:0] fb_din;

    rect_fill_renderer #(
        .W(W), .H(H), .DATA_W(16), .ADDR_W(17), .XW(9), .YW(8)
    ) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x    (cmd_x),
        .cmd_y    (cmd_y),
        .cmd_w    (cmd_w),
        .cmd_h    (cmd_h),
        .cmd_color(cmd_color),
        .busy     (busy),
        .done     (done),
        .fb_en    (fb_en),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_din   (fb_din)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int a;
        int n;
    } cmd_t;
    typedef struct {
        int addr;
        int din;
    } wr_t;

    cmd_t cmd_q[$];
    wr_t  wr_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   cnt = 0;
    int   last_done = -10;
    bit   rst_prev = 1'b1;
    bit   valid_at_done = 1'b0;
    bit   end_req = 1'b0;
    bit   end_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard: models accepted commands, pops and checks every write and done
    always @(negedge clk_sys) begin : mon
        cmd_t c;
        wr_t  w;
        int   n;
        cyc++;
        if (rst_prev) begin
            wr_q.delete();
            cmd_q.delete();
            cnt = 0;
            valid_at_done = 1'b0;
            check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_fb_en", 32'(fb_en), 32'd0);
            check("rst_fb_we", 32'(fb_we), 32'd0);
            check("rst_fb_addr", 32'(fb_addr), 32'd0);
            check("rst_fb_din", 32'(fb_din), 32'd0);
        end else begin
            check("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
            check("we_vs_en", 32'(fb_we), 32'(fb_en));
            if (fb_en === 1'b1) begin
                if (wr_q.size() == 0 || cmd_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write at cycle %0d: got addr %0d expected no write", cyc, fb_addr);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(fb_addr), 32'(w.addr));
                    check("wr_din", 32'(fb_din), 32'(w.din));
                    check("wr_cycle", 32'(cyc), 32'(cmd_q[0].a + 2 + cnt));
                    cnt++;
                end
            end
            if (done === 1'b1) begin
                if (cmd_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done at cycle %0d: got done 1 expected 0", cyc);
                end else begin
                    c = cmd_q.pop_front();
                    check("done_write_count", 32'(cnt), 32'(c.n));
                    check("done_cycle", 32'(cyc), 32'(c.a + c.n + 2));
                end
                cnt = 0;
                last_done = cyc;
                valid_at_done = cmd_valid;
            end
            if (cmd_valid && cmd_ready === 1'b1 && !rst) begin
                if (valid_at_done) check("b2b_accept_cycle", 32'(cyc), 32'(last_done + 1));
                valid_at_done = 1'b0;
                n = 0;
                for (int yy = int'(cmd_y); yy < int'(cmd_y) + int'(cmd_h) && yy < H; yy++) begin
                    for (int xx = int'(cmd_x); xx < int'(cmd_x) + int'(cmd_w) && xx < W; xx++) begin
                        w.addr = yy * W + xx;
                        w.din  = int'(cmd_color);
                        wr_q.push_back(w);
                        n++;
                    end
                end
                c.a = cyc;
                c.n = n;
                cmd_q.push_back(c);
            end
        end
        rst_prev = rst;
        if (end_req && !end_ack) begin
            check("end_writes_pending", 32'(wr_q.size()), 32'd0);
            check("end_cmds_pending", 32'(cmd_q.size()), 32'd0);
            end_ack = 1'b1;
        end
        if (cyc > 30000) begin
            n_chk++;
            n_fail++;
            $display("FAIL watchdog at cycle %0d: got still running expected finished", cyc);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    // Present a command and hold it until the handshake edge
    task automatic issue(input int x, input int y, input int w, input int h,
                         input logic [15:0] c);
        @(posedge clk_sys);
        #1;
        cmd_x     = 9'(x);
        cmd_y     = 8'(y);
        cmd_w     = 9'(w);
        cmd_h     = 8'(h);
        cmd_color = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_sys);
            if (cmd_ready === 1'b1) break;
        end
        @(posedge clk_sys);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_sys);
            if (cmd_ready === 1'b1) break;
        end
    endtask

    // Stimulus
    initial begin
        int nwr;
        repeat (3) @(posedge clk_sys);
        #1;
        rst = 1'b0;

        issue(5, 2, 1, 1, 16'hF800);
        issue(310, 235, 20, 10, 16'h07E0);
        issue(10, 10, 0, 5, 16'h1234);
        issue(400, 0, 4, 4, 16'h4321);
        issue(0, 0, 320, 3, 16'h0000);
        issue(0, 239, 1, 1, 16'hFFFF);
        issue(319, 0, 5, 2, 16'hABCD);

        // valid held high across a whole 4x2 draw; fields change mid-draw
        wait_idle();
        @(posedge clk_sys);
        #1;
        cmd_x = 9'd0; cmd_y = 8'd100; cmd_w = 9'd4; cmd_h = 8'd2;
        cmd_color = 16'h00AA;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_sys);
            if (cmd_ready === 1'b1) break;
        end
        @(posedge clk_sys);
        #1;
        cmd_x = 9'd8;
        cmd_color = 16'h5500;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_sys);
            if (cmd_ready === 1'b1) break;
        end
        @(posedge clk_sys);
        #1;
        cmd_valid = 1'b0;

        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk_sys);
            issue(int'($urandom_range(0, 340)), int'($urandom_range(0, 250)),
                  int'($urandom_range(0, 24)), int'($urandom_range(0, 12)),
                  16'($urandom));
        end

        // reset while the third pixel of a 10x10 is on the bus
        issue(20, 30, 10, 10, 16'h0F0F);
        nwr = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_sys);
            #1;
            if (fb_en === 1'b1) nwr++;
            if (nwr == 3) break;
        end
        rst = 1'b1;
        @(posedge clk_sys);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk_sys);

        issue(100, 50, 3, 2, 16'h7777);
        wait_idle();
        repeat (2) @(posedge clk_sys);

        end_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (end_ack) break;
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
